tick_gen: RTL and testbench

Multi-channel programmable tick generator for the kitchen-timer datapath. It divides the 100 MHz system clock into NUM_CH independent single-cycle tick strobes, with optional 50 % square outputs. Divisors are runtime-loadable through a valid/ready config port and are applied glitch-free at the channel's next wrap. Downstream counters, display scan and the buzzer use the ticks as clock enables; nothing is clocked by a divided clock.

---
 rtl/tick_gen_pkg.sv | 13 +
 rtl/tick_gen_ch.sv | 93 +++++++++
 rtl/tick_gen.sv | 109 ++++++++++
 tb/tb_tick_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the tick generator: divisor floor, default width and config FSM states.
package tick_gen_pkg;

   // Smallest divisor a channel can run with; cnt == act-1 needs act >= 2.
   localparam int unsigned DIV_MIN       = 2;
   localparam int unsigned CNT_W_DEFAULT = 27;

   typedef enum logic [0:0] {
      CFG_IDLE,
      CFG_APPLY
   } cfg_state_e;

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: free-running counter, active divisor, shadow divisor and tick strobe.
// With TICK_GEN_SQUARE_EN defined, a square output toggles on every tick.
module tick_gen_ch
   import tick_gen_pkg::*;
#(
   parameter int unsigned      CNT_W     = CNT_W_DEFAULT,
   parameter logic [CNT_W-1:0] DIV_RESET = CNT_W'(DIV_MIN)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic [CNT_W-1:0] wr_div_i,
   output logic             tick_o
`ifdef TICK_GEN_SQUARE_EN
   ,
   output logic             sq_o
`endif
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic [CNT_W-1:0] shd_q, shd_d;
   logic             tick_q, tick_d;
   logic             wrap;

   assign wrap = (cnt_q == (act_q - CNT_W'(1)));

   // Next-state: sync restarts, otherwise count when enabled and reload act at wrap.
   always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      // A write landing on the wrap edge bypasses straight into act.
      shd_d  = wr_i ? wr_div_i : shd_q;
      tick_d = 1'b0;
      if (sync_i) begin
         cnt_d = '0;
         act_d = shd_d;
      end else if (en_i) begin
         if (wrap) begin
            cnt_d  = '0;
            act_d  = shd_d;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Channel state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         act_q  <= DIV_RESET;
         shd_q  <= DIV_RESET;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         act_q  <= act_d;
         shd_q  <= shd_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

`ifdef TICK_GEN_SQUARE_EN
   logic sq_q, sq_d;

   // Square output flips on each tick; sync clears it.
   always_comb begin
      sq_d = sq_q;
      if (sync_i) begin
         sq_d = 1'b0;
      end else if (en_i && wrap) begin
         sq_d = ~sq_q;
      end
   end

   // Square output register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sq_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
      end
   end

   assign sq_o = sq_q;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel programmable tick generator: config FSM, request validation and per-channel
// write decode around NUM_CH tick_gen_ch instances. Define TICK_GEN_SQUARE_EN for sq_o.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 100_000_000,
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_W     = CNT_W_DEFAULT,
   parameter int unsigned DIV_RESET = CLK_HZ / 1000,
   localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic              sync_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [CH_W-1:0]   cfg_ch_i,
   input  logic [CNT_W-1:0]  cfg_div_i,
   output logic              cfg_err_o,
   output logic [NUM_CH-1:0] tick_o
`ifdef TICK_GEN_SQUARE_EN
   ,
   output logic [NUM_CH-1:0] sq_o
`endif
);

   localparam logic [CNT_W-1:0] DivResetC = CNT_W'(DIV_RESET);

   cfg_state_e        state_q, state_d;
   logic [CH_W-1:0]   req_ch_q;
   logic [CNT_W-1:0]  req_div_q;
   logic              err_q;
   logic              accept;
   logic              apply;
   logic              req_bad;
   logic [NUM_CH-1:0] wr_en;

   // Config FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= CFG_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Config FSM next state: APPLY always lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CFG_IDLE:  if (cfg_valid_i) state_d = CFG_APPLY;
         CFG_APPLY: state_d = CFG_IDLE;
      endcase
   end

   // Config FSM outputs.
   always_comb begin
      cfg_ready_o = 1'b0;
      apply       = 1'b0;
      unique case (state_q)
         CFG_IDLE:  cfg_ready_o = 1'b1;
         CFG_APPLY: apply       = 1'b1;
      endcase
   end

   assign accept  = cfg_valid_i && cfg_ready_o;
   assign req_bad = (cfg_div_i < CNT_W'(DIV_MIN)) ||
                    ({{(32 - CH_W){1'b0}}, cfg_ch_i} >= 32'(NUM_CH));

   // Capture the request at accept; the error flag is high for the whole APPLY cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_ch_q  <= '0;
         req_div_q <= '0;
         err_q     <= 1'b0;
      end else if (accept) begin
         req_ch_q  <= cfg_ch_i;
         req_div_q <= cfg_div_i;
         err_q     <= req_bad;
      end else begin
         err_q     <= 1'b0;
      end
   end

   assign cfg_err_o = err_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign wr_en[i] = apply && !err_q && (req_ch_q == CH_W'(i));

      tick_gen_ch #(
         .CNT_W     (CNT_W),
         .DIV_RESET (DivResetC)
      ) u_ch (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .en_i     (en_i),
         .sync_i   (sync_i),
         .wr_i     (wr_en[i]),
         .wr_div_i (req_div_q),
         .tick_o   (tick_o[i])
`ifdef TICK_GEN_SQUARE_EN
         ,
         .sq_o     (sq_o[i])
`endif
      );
   end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: a countdown reference model pushes the expected outputs of
// every cycle into a queue and a negedge monitor pops and compares them.
module tb_tick_gen;

   localparam int unsigned NUM_CH    = 5;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned DIV_RESET = 20;
   localparam int unsigned CH_W      = 3;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b1;
   logic              en        = 1'b0;
   logic              sync      = 1'b0;
   logic              cfg_valid = 1'b0;
   logic [CH_W-1:0]   cfg_ch    = '0;
   logic [CNT_W-1:0]  cfg_div   = '0;
   logic              cfg_ready;
   logic              cfg_err;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;

   always #5 clk = ~clk;

`ifndef TICK_GEN_SQUARE_EN
   assign sq = '0;
`endif

   tick_gen #(
      .CLK_HZ    (20_000),
      .NUM_CH    (NUM_CH),
      .CNT_W     (CNT_W),
      .DIV_RESET (DIV_RESET)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (en),
      .sync_i      (sync),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_ch_i    (cfg_ch),
      .cfg_div_i   (cfg_div),
      .cfg_err_o   (cfg_err),
      .tick_o      (tick)
`ifdef TICK_GEN_SQUARE_EN
      ,
      .sq_o        (sq)
`endif
   );

   typedef struct packed {
      logic [NUM_CH-1:0] tick;
      logic [NUM_CH-1:0] sq;
      logic              ready;
      logic              err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: cycles remaining until each channel's next tick.
   int left[NUM_CH];
   int shd[NUM_CH];
   bit msq[NUM_CH];
   bit m_apply, m_err;
   int m_ch, m_div;

   task automatic check(input string nm, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         left[i] = DIV_RESET;
         shd[i]  = DIV_RESET;
         msq[i]  = 1'b0;
      end
      m_apply = 1'b0;
      m_err   = 1'b0;
      m_ch    = 0;
      m_div   = 0;
   endtask

   task automatic model_step();
      exp_t e;
      bit   wr;
      int   wch, wdiv;
      wr   = m_apply && !m_err;
      wch  = m_ch;
      wdiv = m_div;
      if (m_apply) begin
         m_apply = 1'b0;
         m_err   = 1'b0;
      end else if (cfg_valid) begin
         m_apply = 1'b1;
         m_ch    = int'(cfg_ch);
         m_div   = int'(cfg_div);
         m_err   = (m_div < 2) || (m_ch >= NUM_CH);
      end
      for (int i = 0; i < NUM_CH; i++) begin
         int nshd;
         nshd      = (wr && wch == i) ? wdiv : shd[i];
         e.tick[i] = 1'b0;
         if (sync) begin
            left[i] = nshd;
            msq[i]  = 1'b0;
         end else if (en) begin
            left[i]--;
            if (left[i] == 0) begin
               e.tick[i] = 1'b1;
               left[i]   = nshd;
               msq[i]    = !msq[i];
            end
         end
         shd[i]  = nshd;
         e.sq[i] = msq[i];
      end
`ifndef TICK_GEN_SQUARE_EN
      e.sq = '0;
`endif
      e.ready = !m_apply;
      e.err   = m_err;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Monitor: compare every presented cycle against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         check("reset_tick", int'(tick), 0);
         check("reset_sq", int'(sq), 0);
         check("reset_ready", int'(cfg_ready), 1);
         check("reset_err", int'(cfg_err), 0);
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("tick", int'(tick), int'(e.tick));
         check("cfg_ready", int'(cfg_ready), int'(e.ready));
         check("cfg_err", int'(cfg_err), int'(e.err));
`ifdef TICK_GEN_SQUARE_EN
         check("sq", int'(sq), int'(e.sq));
`endif
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic cfg(input int ch, input int div);
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = CNT_W'(div);
      step(1);
      cfg_valid = 1'b0;
      step(1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      en    = 1'b1;
      step(50);
      // Divisor change mid-period.
      cfg(1, 6);
      step(40);
      // Rejected requests: divisor too small, channel out of range.
      cfg(2, 1);
      cfg(7, 5);
      step(30);
      // Held valid: accepts every other cycle.
      cfg_valid = 1'b1;
      cfg_ch    = 3'd3;
      cfg_div   = 8'd7;
      step(4);
      cfg_valid = 1'b0;
      step(20);
      // Enable gap.
      cfg(0, 5);
      step(9);
      en = 1'b0;
      step(3);
      en = 1'b1;
      step(20);
      // Write then sync.
      cfg(0, 4);
      sync = 1'b1;
      step(1);
      sync = 1'b0;
      step(30);
      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         en        = ($urandom_range(0, 7) != 0);
         sync      = ($urandom_range(0, 99) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = CH_W'($urandom_range(0, 7));
         cfg_div   = CNT_W'($urandom_range(0, 12));
         step(1);
      end
      // Reset in the middle of activity.
      en        = 1'b1;
      sync      = 1'b0;
      cfg_valid = 1'b1;
      cfg_ch    = 3'd1;
      cfg_div   = 8'd3;
      step(1);
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(60);
      step(1);
      if (n_checks < 12) begin
         n_fail++;
         $display("FAIL check_count: got %0d expected at least 12", n_checks);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
